decode_ctrl_seq: RTL and testbench
==================================

DECODE_CTRL_SEQ -- requirements
Module: decode_ctrl_seq

Interface
REQ-001 Parameter OP_W, default 7: opcode width; SHALL be >= 7.
REQ-002 Parameter N_TPU_MAT, default 3: TPU operand-matrix load channels; legal range 1..3.
REQ-003 Parameter CNT_W, default 16: TPU busy-cycle counter width.
REQ-004 Port clk  in  1  sole clock, rising edge.
REQ-005 Port rst  in  1  reset, asynchronous, active-high.
REQ-006 Port instr_valid_i  in  1  upstream opcode valid.
REQ-007 Port op_i  in  OP_W  opcode.
REQ-008 Port instr_ready_o  out  1  decoder accepts op_i this cycle.
REQ-009 Port ex_ready_i  in  1  downstream accepts the registered control bundle.
REQ-010 Port flush_i  in  1  discard the registered bundle.
REQ-011 Port tpu_done_i  in  1  TPU finished matmul, single-cycle pulse.
REQ-012 Port ctrl_valid_o  out  1  registered bundle valid.
REQ-013 Bundle outputs, all registered: imm_sel_o 1; alu_op_o 4; branch_type_o 2; wb_sel_o 2; reg_write_enable_o, mem_write_enable_o, mem_cache_valid_o, tpu_start_o 1 each; tpu_write_enable_o N_TPU_MAT.
REQ-014 Port illegal_op_o  out  1  registered bundle holds an undefined opcode.
REQ-015 Port tpu_busy_o  out  1  FSM in TPU_WAIT.
REQ-016 Port tpu_cycles_o  out  CNT_W  length of the current or last TPU_WAIT, in cycles.

Function
REQ-017 Opcode map: 0x00 nop; 0x01-0x0A ALU R-type; 0x11, 0x13-0x19, 0x1B ALU I-type; 0x20 lw; 0x21 sw; 0x3C-0x3F branches; 0x50 matmul; 0x51+k load matrix k (k < N_TPU_MAT); 0x54 racc; 0x7E j; 0x7F jr.
REQ-018 Any other value, including op_i[OP_W-1:7] != 0, SHALL set illegal_op_o=1 with every enable bit 0.
REQ-019 Decode per op[6:0]:
- imm_sel = op[4]^op[5].
- wb_sel[0] = op[6:4]==3'b010; wb_sel[1] = op[6:4]==3'b101.
- alu_op = 4'h1 when wb_sel[0], else op[3:0].
- branch_type = 01 for op[6:4]==3'b011; {1,op[0]} for op[6:1] all ones; else 00.
REQ-020 Enables: reg_write for ALU ops, lw and racc; mem_write for sw; mem_cache_valid for lw/sw; tpu_start for matmul; tpu_write_enable_o[k] for 0x51+k.
REQ-021 Accept when instr_valid_i && instr_ready_o; bundle appears with ctrl_valid_o=1 the next cycle (latency 1).
REQ-022 instr_ready_o = (!ctrl_valid_o || ex_ready_i) && !flush_i && !stall.
REQ-023 stall = op_i is TPU-class (0x50-0x54) && (state==TPU_WAIT || (ctrl_valid_o && tpu_start_o)).
REQ-024 Non-TPU ops SHALL NOT stall during TPU_WAIT.
REQ-025 ctrl_valid_o falls after a downstream handshake with no accept in the same cycle; the bundle is held while ctrl_valid_o && !ex_ready_i.
REQ-026 flush_i clears ctrl_valid_o and illegal_op_o next cycle.
REQ-027 flush_i SHALL NOT change FSM state or the counter.
REQ-028 FSM RUN->TPU_WAIT on a handshake (ctrl_valid_o && ex_ready_i) carrying tpu_start_o, unless flush_i is high that cycle.
REQ-029 FSM TPU_WAIT->RUN the cycle after tpu_done_i; stall is evaluated from registered state, so a stalled op is accepted one cycle after done at the earliest.
REQ-030 tpu_done_i while in RUN SHALL be ignored.
REQ-031 tpu_cycles_o clears to 1 on entry to TPU_WAIT, increments each TPU_WAIT cycle, saturates at all-ones, and holds in RUN.

Reset
REQ-032 Asynchronous rst SHALL force: state RUN, ctrl_valid_o=0, all bundle outputs 0, illegal_op_o=0, tpu_cycles_o=0.
REQ-033 Reset during TPU_WAIT SHALL abandon the wait; a later tpu_done_i is ignored.

Structure
REQ-034 Shared package ctrl_pkg SHALL hold opcode constants, the ALU-op enum, branch_type and wb_sel encodings, and the FSM state enum.
REQ-035 Combinational decode SHALL live in sub-module op_decode (opcode in, bundle plus illegal flag out); decode_ctrl_seq owns the register, handshake, FSM and counter.

Verification
REQ-036 op 0x01 valid, ex_ready_i=1 -> next cycle ctrl_valid_o=1, reg_write_enable_o=1, alu_op_o=1, imm_sel_o=0.
REQ-037 Backpressure: 0x20 accepted, ex_ready_i=0 for 3 cycles -> bundle held with wb_sel_o=01, alu_op_o=1; instr_ready_o=0 throughout.
REQ-038 0x50 handshaked, then 0x52 presented -> stalled while 0x03 passes; tpu_done_i after 10 waiting cycles -> tpu_cycles_o=10, then 0x52 accepted with tpu_write_enable_o=3'b010.
REQ-039 N_TPU_MAT=2: op 0x53 -> illegal_op_o=1, tpu_write_enable_o=0; op_i=0x81 with OP_W=8 -> illegal_op_o=1.
REQ-040 flush_i with 0x21 pending -> ctrl_valid_o=0 next cycle, no mem_write_enable_o handshake; flush in TPU_WAIT -> tpu_busy_o stays 1.
REQ-041 rst asserted mid-TPU_WAIT -> outputs 0 immediately (asynchronous); after release, 0x51 accepted without waiting for tpu_done_i.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared opcode constants, control-field encodings and sequencer state for the decode stage.
package ctrl_pkg;

  localparam logic [6:0] OpNop    = 7'h00;
  localparam logic [6:0] OpLw     = 7'h20;
  localparam logic [6:0] OpSw     = 7'h21;
  localparam logic [6:0] OpMatmul = 7'h50;
  localparam logic [6:0] OpLdMat0 = 7'h51;
  localparam logic [6:0] OpRacc   = 7'h54;
  localparam logic [6:0] OpJ      = 7'h7E;
  localparam logic [6:0] OpJr     = 7'h7F;

  typedef enum logic [3:0] {
    AluNop = 4'h0,
    AluAdd = 4'h1,
    AluSub = 4'h2
  } alu_op_e;

  typedef enum logic [1:0] {
    BrNone = 2'b00,
    BrCond = 2'b01,
    BrJ    = 2'b10,
    BrJr   = 2'b11
  } branch_e;

  localparam logic [1:0] WbAlu = 2'b00;
  localparam logic [1:0] WbMem = 2'b01;
  localparam logic [1:0] WbTpu = 2'b10;

  typedef enum logic {
    StRun,
    StTpuWait
  } state_e;

endpackage

// File: rtl/op_decode.sv
// Combinational opcode decoder: produces the control bundle and an illegal flag.
module op_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned OP_W      = 7,
  parameter int unsigned N_TPU_MAT = 3
) (
  input  logic [OP_W-1:0]      op_i,
  output logic                 imm_sel_o,
  output logic [3:0]           alu_op_o,
  output logic [1:0]           branch_type_o,
  output logic [1:0]           wb_sel_o,
  output logic                 reg_write_enable_o,
  output logic                 mem_write_enable_o,
  output logic                 mem_cache_valid_o,
  output logic                 tpu_start_o,
  output logic [N_TPU_MAT-1:0] tpu_write_enable_o,
  output logic                 illegal_op_o
);

  logic [6:0]      op7;
  logic [OP_W-1:0] op_hi;
  logic            is_alu, is_br, is_ld, legal;

  always_comb begin
    op7   = op_i[6:0];
    op_hi = op_i >> 7;
    is_alu = (op7 >= 7'h01 && op7 <= 7'h0A) || op7 == 7'h11 ||
             (op7 >= 7'h13 && op7 <= 7'h19) || op7 == 7'h1B;
    is_br  = op7 >= 7'h3C && op7 <= 7'h3E;
    is_ld  = op7 >= OpLdMat0 && op7 < 7'(8'h51 + N_TPU_MAT);
    legal  = (op_hi == '0) &&
             (op7 == OpNop || is_alu || op7 == OpLw || op7 == OpSw || is_br ||
              op7 == 7'h3F || op7 == OpMatmul || is_ld || op7 == OpRacc ||
              op7 == OpJ || op7 == OpJr);

    imm_sel_o          = 1'b0;
    alu_op_o           = AluNop;
    branch_type_o      = BrNone;
    wb_sel_o           = WbAlu;
    reg_write_enable_o = 1'b0;
    mem_write_enable_o = 1'b0;
    mem_cache_valid_o  = 1'b0;
    tpu_start_o        = 1'b0;
    tpu_write_enable_o = '0;
    illegal_op_o       = !legal;

    // Illegal opcodes leave the whole bundle at zero.
    if (legal) begin
      imm_sel_o   = op7[4] ^ op7[5];
      wb_sel_o[0] = op7[6:4] == 3'b010;
      wb_sel_o[1] = op7[6:4] == 3'b101;
      alu_op_o    = wb_sel_o[0] ? AluAdd : op7[3:0];
      if (op7[6:4] == 3'b011) begin
        branch_type_o = BrCond;
      end else if (&op7[6:1]) begin
        branch_type_o = {1'b1, op7[0]};
      end
      reg_write_enable_o = is_alu || op7 == OpLw || op7 == OpRacc;
      mem_write_enable_o = op7 == OpSw;
      mem_cache_valid_o  = op7 == OpLw || op7 == OpSw;
      tpu_start_o        = op7 == OpMatmul;
      for (int k = 0; k < int'(N_TPU_MAT); k++) begin
        tpu_write_enable_o[k] = op7 == 7'(8'h51 + k);
      end
    end
  end

endmodule

// File: rtl/decode_ctrl_seq.sv
// Decode stage: registered control bundle with valid/ready handshake and a TPU wait sequencer.
module decode_ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int unsigned OP_W      = 7,
  parameter int unsigned N_TPU_MAT = 3,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid_i,
  input  logic [OP_W-1:0]      op_i,
  output logic                 instr_ready_o,
  input  logic                 ex_ready_i,
  input  logic                 flush_i,
  input  logic                 tpu_done_i,
  output logic                 ctrl_valid_o,
  output logic                 imm_sel_o,
  output logic [3:0]           alu_op_o,
  output logic [1:0]           branch_type_o,
  output logic [1:0]           wb_sel_o,
  output logic                 reg_write_enable_o,
  output logic                 mem_write_enable_o,
  output logic                 mem_cache_valid_o,
  output logic                 tpu_start_o,
  output logic [N_TPU_MAT-1:0] tpu_write_enable_o,
  output logic                 illegal_op_o,
  output logic                 tpu_busy_o,
  output logic [CNT_W-1:0]     tpu_cycles_o
);

  localparam int unsigned BW = 14 + N_TPU_MAT;

  logic                 d_imm, d_rw, d_mw, d_mc, d_ts, d_ill;
  logic [3:0]           d_alu;
  logic [1:0]           d_br, d_wb;
  logic [N_TPU_MAT-1:0] d_twe;

  op_decode #(
    .OP_W      (OP_W),
    .N_TPU_MAT (N_TPU_MAT)
  ) u_op_decode (
    .op_i               (op_i),
    .imm_sel_o          (d_imm),
    .alu_op_o           (d_alu),
    .branch_type_o      (d_br),
    .wb_sel_o           (d_wb),
    .reg_write_enable_o (d_rw),
    .mem_write_enable_o (d_mw),
    .mem_cache_valid_o  (d_mc),
    .tpu_start_o        (d_ts),
    .tpu_write_enable_o (d_twe),
    .illegal_op_o       (d_ill)
  );

  state_e          state_q, state_d;
  logic            valid_q, valid_d;
  logic [BW-1:0]   bun_q, bun_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            tpu_class, stall, accept, handshake;

  assign {illegal_op_o, imm_sel_o, alu_op_o, branch_type_o, wb_sel_o, reg_write_enable_o,
          mem_write_enable_o, mem_cache_valid_o, tpu_start_o, tpu_write_enable_o} = bun_q;
  assign ctrl_valid_o = valid_q;
  assign tpu_busy_o   = state_q == StTpuWait;
  assign tpu_cycles_o = cnt_q;

  always_comb begin
    tpu_class = op_i >= OP_W'(8'h50) && op_i <= OP_W'(8'h54);
    // Stall decisions use registered state only, so release comes a cycle after done.
    stall         = tpu_class && (state_q == StTpuWait || (valid_q && tpu_start_o));
    instr_ready_o = (!valid_q || ex_ready_i) && !flush_i && !stall;
    accept        = instr_valid_i && instr_ready_o;
    handshake     = valid_q && ex_ready_i;

    valid_d = valid_q;
    bun_d   = bun_q;
    if (flush_i) begin
      valid_d = 1'b0;
      bun_d   = '0;
    end else if (accept) begin
      valid_d = 1'b1;
      bun_d   = {d_ill, d_imm, d_alu, d_br, d_wb, d_rw, d_mw, d_mc, d_ts, d_twe};
    end else if (handshake) begin
      valid_d = 1'b0;
      bun_d   = '0;
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun: begin
        if (handshake && tpu_start_o && !flush_i) begin
          state_d = StTpuWait;
          cnt_d   = CNT_W'(1);
        end
      end
      StTpuWait: begin
        if (tpu_done_i) begin
          state_d = StRun;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      valid_q <= 1'b0;
      bun_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      bun_q   <= bun_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_decode_ctrl_seq.sv
// Self-checking bench: directed scenarios then random traffic against a behavioural model.
module tb_decode_ctrl_seq;

  localparam int OPW  = 8;
  localparam int NMAT = 2;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            instr_valid_i = 1'b0;
  logic [OPW-1:0]  op_i = '0;
  logic            instr_ready_o;
  logic            ex_ready_i = 1'b0;
  logic            flush_i = 1'b0;
  logic            tpu_done_i = 1'b0;
  logic            ctrl_valid_o, imm_sel_o, reg_write_enable_o, mem_write_enable_o;
  logic            mem_cache_valid_o, tpu_start_o, illegal_op_o, tpu_busy_o;
  logic [3:0]      alu_op_o;
  logic [1:0]      branch_type_o, wb_sel_o;
  logic [NMAT-1:0] tpu_write_enable_o;
  logic [CW-1:0]   tpu_cycles_o;

  decode_ctrl_seq #(
    .OP_W      (OPW),
    .N_TPU_MAT (NMAT),
    .CNT_W     (CW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .instr_valid_i      (instr_valid_i),
    .op_i               (op_i),
    .instr_ready_o      (instr_ready_o),
    .ex_ready_i         (ex_ready_i),
    .flush_i            (flush_i),
    .tpu_done_i         (tpu_done_i),
    .ctrl_valid_o       (ctrl_valid_o),
    .imm_sel_o          (imm_sel_o),
    .alu_op_o           (alu_op_o),
    .branch_type_o      (branch_type_o),
    .wb_sel_o           (wb_sel_o),
    .reg_write_enable_o (reg_write_enable_o),
    .mem_write_enable_o (mem_write_enable_o),
    .mem_cache_valid_o  (mem_cache_valid_o),
    .tpu_start_o        (tpu_start_o),
    .tpu_write_enable_o (tpu_write_enable_o),
    .illegal_op_o       (illegal_op_o),
    .tpu_busy_o         (tpu_busy_o),
    .tpu_cycles_o       (tpu_cycles_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            ill;
    logic            imm;
    logic [3:0]      alu;
    logic [1:0]      br;
    logic [1:0]      wb;
    logic            rw, mw, mc, ts;
    logic [NMAT-1:0] twe;
  } exp_t;

  int vecs = 0;
  int errs = 0;

  // Model state: pending bundle, whether the TPU is being waited on, wait length.
  bit m_valid = 0;
  int m_op    = 0;
  bit m_wait  = 0;
  int m_cnt   = 0;

  function automatic exp_t ref_dec(int op);
    exp_t e = '0;
    int   hi = op / 16;
    int   lo = op % 16;
    bit   alu = op inside {[1:10], 'h11, ['h13:'h19], 'h1B};
    bit   ld  = op inside {['h51:'h51 + NMAT - 1]};
    bit   ok  = alu || ld || op inside {0, 'h20, 'h21, ['h3C:'h3F], 'h50, 'h54, 'h7E, 'h7F};
    if (!ok) begin
      e.ill = 1'b1;
      return e;
    end
    e.imm = (hi % 4) inside {1, 2};
    e.wb  = (hi == 2) ? 2'b01 : (hi == 5) ? 2'b10 : 2'b00;
    e.alu = (hi == 2) ? 4'd1 : 4'(lo);
    e.br  = (hi == 3) ? 2'b01 : (op >= 'h7E) ? 2'(2 + op % 2) : 2'b00;
    e.rw  = alu || op == 'h20 || op == 'h54;
    e.mw  = op == 'h21;
    e.mc  = op == 'h20 || op == 'h21;
    e.ts  = op == 'h50;
    if (ld) e.twe[op - 'h51] = 1'b1;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    exp_t e = m_valid ? ref_dec(m_op) : '0;
    chk("ctrl_valid", 32'(ctrl_valid_o), 32'(m_valid));
    chk("illegal", 32'(illegal_op_o), 32'(e.ill));
    chk("imm_sel", 32'(imm_sel_o), 32'(e.imm));
    chk("alu_op", 32'(alu_op_o), 32'(e.alu));
    chk("branch", 32'(branch_type_o), 32'(e.br));
    chk("wb_sel", 32'(wb_sel_o), 32'(e.wb));
    chk("enables", 32'({reg_write_enable_o, mem_write_enable_o, mem_cache_valid_o, tpu_start_o}),
        32'({e.rw, e.mw, e.mc, e.ts}));
    chk("tpu_we", 32'(tpu_write_enable_o), 32'(e.twe));
    chk("tpu_busy", 32'(tpu_busy_o), 32'(m_wait));
    chk("tpu_cycles", 32'(tpu_cycles_o), 32'(m_cnt));
  endtask

  task automatic step(input bit v, input int op, input bit exr, input bit fl, input bit dn);
    bit tpu, start, stall, rdy;
    @(negedge clk);
    instr_valid_i = v;
    op_i          = OPW'(op);
    ex_ready_i    = exr;
    flush_i       = fl;
    tpu_done_i    = dn;
    #1;
    check_outputs();
    tpu   = op inside {['h50:'h54]};
    start = m_valid && m_op == 'h50;
    stall = tpu && (m_wait || start);
    rdy   = (!m_valid || exr) && !fl && !stall;
    chk("instr_ready", 32'(instr_ready_o), 32'(rdy));
    if (m_wait) begin
      if (dn) m_wait = 0;
      else if (m_cnt < CMAX) m_cnt++;
    end else if (start && exr && !fl) begin
      m_wait = 1;
      m_cnt  = 1;
    end
    if (fl) m_valid = 0;
    else if (v && rdy) begin
      m_valid = 1;
      m_op    = op;
    end else if (m_valid && exr) m_valid = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    m_valid = 0;
    m_wait  = 0;
    m_cnt   = 0;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int pool[16] = '{'h00, 'h01, 'h0A, 'h11, 'h1B, 'h20, 'h21, 'h3C,
                   'h3F, 'h50, 'h51, 'h52, 'h53, 'h54, 'h7E, 'h7F};

  initial begin
    @(negedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // Simple ALU op, latency one
    step(1, 'h01, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("r036_rw", 32'(reg_write_enable_o), 32'd1);

    // Backpressure holds a load bundle
    step(1, 'h20, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 'h05, 0, 0, 0);
    chk("r037_wb", 32'(wb_sel_o), 32'd1);
    chk("r037_ready", 32'(instr_ready_o), 32'd0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);

    // Matmul then a stalled matrix load while ALU ops pass
    step(1, 'h50, 1, 0, 0);
    step(1, 'h52, 1, 0, 0);
    for (int k = 1; k <= 10; k++) step(1, (k % 2) ? 'h52 : 'h03, 1, 0, k == 10);
    chk("r038_cycles", 32'(tpu_cycles_o), 32'd10);
    step(1, 'h52, 1, 0, 0);
    chk("r038_ready", 32'(instr_ready_o), 32'd1);
    step(0, 0, 1, 0, 0);
    chk("r038_twe", 32'(tpu_write_enable_o), 32'b10);

    // Channel beyond N_TPU_MAT and nonzero high opcode bits are illegal
    step(1, 'h53, 1, 0, 0);
    step(1, 'h81, 1, 0, 0);
    chk("r039_ill53", 32'(illegal_op_o), 32'd1);
    step(0, 0, 1, 0, 0);
    chk("r039_ill81", 32'(illegal_op_o), 32'd1);

    // Counter saturation
    step(1, 'h50, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 0);
    chk("sat_cycles", 32'(tpu_cycles_o), 32'(CMAX));
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 0);

    // Flush drops a pending store; flush does not leave TPU_WAIT
    step(1, 'h21, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    chk("r040_mw", 32'(mem_write_enable_o), 32'd0);
    step(1, 'h50, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(1, 'h03, 1, 0, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    chk("r040_busy", 32'(tpu_busy_o), 32'd1);

    // Reset abandons the wait
    do_reset();
    step(1, 'h51, 1, 0, 0);
    chk("r041_ready", 32'(instr_ready_o), 32'd1);
    step(0, 0, 1, 0, 1);
    chk("r041_twe", 32'(tpu_write_enable_o), 32'b01);
    step(0, 0, 1, 0, 0);

    for (int i = 0; i < 600; i++) begin
      int op = ($urandom % 4 == 0) ? int'($urandom % 256) : pool[$urandom % 16];
      step($urandom % 4 != 0, op, $urandom % 4 != 0, $urandom % 12 == 0, $urandom % 6 == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
